hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the five-stage core. Watches the ID stage and the ID/EX register contents.

---
 rtl/hazard_ctrl_pkg.sv | 35 +++
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/sat_counter.sv | 22 ++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_hazard_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: writeback select codes,
// FSM state encoding and the bundled pipeline control word.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    WB_NONE = 2'b00,
    WB_ALU  = 2'b01,
    WB_DMEM = 2'b10,
    WB_PC4  = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_STALL  = 2'd1,
    HZ_FLUSH  = 2'd2,
    HZ_FREEZE = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_hold;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_hold;
    logic idex_bubble;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_NONE   = hz_ctrl_t'(5'b00000);
  localparam hz_ctrl_t CTRL_LU     = hz_ctrl_t'(5'b11001);
  localparam hz_ctrl_t CTRL_FLUSH  = hz_ctrl_t'(5'b00101);
  localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(5'b11010);

  // Width of the stall/flush down-counters; parameters are limited to 0..7.
  localparam int DCNT_W = 3;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID/EX observations in,
// hold/bubble/flush controls and performance counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [4:0]       ex_rd;
  logic [1:0]       ex_wb_select;
  logic             ex_pc_sel;
  logic             dmem_busy;
  logic             cnt_clr;
  logic             pc_hold;
  logic             ifid_hold;
  logic             ifid_flush;
  logic             idex_hold;
  logic             idex_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_wb_select,
           ex_pc_sel, dmem_busy, cnt_clr,
    input  pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_wb_select,
           ex_pc_sel, dmem_busy, cnt_clr,
    output pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && !(&q)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, redirect flush and
// data-memory freeze, plus saturating stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LU_STALL  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [DCNT_W-1:0] SCNT_LOAD = DCNT_W'(LU_STALL - 1);
  localparam logic [DCNT_W-1:0] FCNT_LOAD = DCNT_W'(FLUSH_CYC);

  hz_state_e         state, state_d, saved, saved_d, eval_state;
  logic [DCNT_W-1:0] scnt, scnt_d, fcnt, fcnt_d;
  hz_ctrl_t          ctrl;
  logic              lu_hit;
  logic              flush_inc;

  assign lu_hit = (wb_sel_e'(hz.ex_wb_select) == WB_DMEM) && (hz.ex_rd != 5'd0) &&
                  ((hz.id_rs1_used && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_rs2_used && (hz.id_rs2 == hz.ex_rd)));

  // Leaving FREEZE resumes the interrupted state within the same cycle.
  assign eval_state = (state == HZ_FREEZE) ? saved : state;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_d   = eval_state;
    saved_d   = saved;
    scnt_d    = scnt;
    fcnt_d    = fcnt;
    ctrl      = CTRL_NONE;
    flush_inc = 1'b0;
    if (hz.dmem_busy) begin
      ctrl    = CTRL_FREEZE;
      state_d = HZ_FREEZE;
      if (state != HZ_FREEZE) saved_d = state;
    end else begin
      case (eval_state)
        HZ_RUN: begin
          if (hz.ex_pc_sel) begin
            ctrl      = CTRL_FLUSH;
            flush_inc = 1'b1;
            if (FLUSH_CYC > 0) begin
              state_d = HZ_FLUSH;
              fcnt_d  = FCNT_LOAD;
            end
          end else if (lu_hit) begin
            ctrl = CTRL_LU;
            if (LU_STALL > 1) begin
              state_d = HZ_STALL;
              scnt_d  = SCNT_LOAD;
            end
          end
        end
        // EX holds a bubble in STALL and FLUSH, so neither a redirect nor a
        // load-use hit can arrive here.
        HZ_STALL: begin
          ctrl   = CTRL_LU;
          scnt_d = scnt - DCNT_W'(1);
          if (scnt == DCNT_W'(1)) state_d = HZ_RUN;
        end
        HZ_FLUSH: begin
          ctrl   = CTRL_FLUSH;
          fcnt_d = fcnt - DCNT_W'(1);
          if (fcnt == DCNT_W'(1)) state_d = HZ_RUN;
        end
        default: state_d = HZ_RUN;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= HZ_RUN;
      saved <= HZ_RUN;
      scnt  <= '0;
      fcnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_d;
      saved <= saved_d;
      scnt  <= scnt_d;
      fcnt  <= fcnt_d;
    end
  end

  // Controls are forced low while reset is asserted, independent of the clock.
  assign hz.pc_hold     = sys_rst & ctrl.pc_hold;
  assign hz.ifid_hold   = sys_rst & ctrl.ifid_hold;
  assign hz.ifid_flush  = sys_rst & ctrl.ifid_flush;
  assign hz.idex_hold   = sys_rst & ctrl.idex_hold;
  assign hz.idex_bubble = sys_rst & ctrl.idex_bubble;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (hz.cnt_clr),
    .inc     (ctrl.pc_hold),
    .q       (hz.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (hz.cnt_clr),
    .inc     (flush_inc),
    .q       (hz.flush_cnt)
  );

  a_no_hold_flush: assert property (@(posedge sys_clk) disable iff (!sys_rst)
                                    !(hz.pc_hold && hz.ifid_flush));
  a_no_hold_bubble: assert property (@(posedge sys_clk) disable iff (!sys_rst)
                                     !(hz.idex_hold && hz.idex_bubble));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (default timing with 4-bit
// counters, and LU_STALL=3/FLUSH_CYC=2 with 8-bit counters) share one stimulus.
module tb_hazard_ctrl;

  // Control word order: {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] LU = 5'b11001;
  localparam logic [4:0] FL = 5'b00101;
  localparam logic [4:0] FZ = 5'b11010;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic [1:0] wb;
    logic       pc_sel;
    logic       busy;
    logic       clr;
    logic       rst;
  } in_t;

  typedef struct {
    string      nm;
    logic [4:0] c0;
    logic [4:0] c1;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   total   = 0;
  int   passed  = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 sys_clk = ~sys_clk;

  hazard_ctrl_if #(.CNT_W(4)) if0 ();
  hazard_ctrl_if #(.CNT_W(8)) if1 ();

  hazard_ctrl #(.LU_STALL(1), .FLUSH_CYC(1), .CNT_W(4)) dut0 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .hz      (if0)
  );

  hazard_ctrl #(.LU_STALL(3), .FLUSH_CYC(2), .CNT_W(8)) dut1 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .hz      (if1)
  );

  function automatic in_t idle_in();
    in_t s;
    s     = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic in_t hit_in(input logic [4:0] r);
    in_t s;
    s     = idle_in();
    s.rs1 = r;
    s.u1  = 1'b1;
    s.rd  = r;
    s.wb  = 2'b10;
    return s;
  endfunction

  function automatic in_t pcsel_in();
    in_t s;
    s        = idle_in();
    s.pc_sel = 1'b1;
    return s;
  endfunction

  function automatic in_t busy_in();
    in_t s;
    s      = idle_in();
    s.busy = 1'b1;
    return s;
  endfunction

  task automatic apply(input in_t s);
    sys_rst          = s.rst;
    if0.id_rs1       = s.rs1;  if1.id_rs1       = s.rs1;
    if0.id_rs2       = s.rs2;  if1.id_rs2       = s.rs2;
    if0.id_rs1_used  = s.u1;   if1.id_rs1_used  = s.u1;
    if0.id_rs2_used  = s.u2;   if1.id_rs2_used  = s.u2;
    if0.ex_rd        = s.rd;   if1.ex_rd        = s.rd;
    if0.ex_wb_select = s.wb;   if1.ex_wb_select = s.wb;
    if0.ex_pc_sel    = s.pc_sel; if1.ex_pc_sel  = s.pc_sel;
    if0.dmem_busy    = s.busy; if1.dmem_busy    = s.busy;
    if0.cnt_clr      = s.clr;  if1.cnt_clr      = s.clr;
  endtask

  // One cycle of stimulus; the expected control words for both DUTs go to the scoreboard.
  task automatic drive(input in_t s, input logic [4:0] e0, input logic [4:0] e1, input string nm);
    exp_t e;
    @(posedge sys_clk);
    #1;
    apply(s);
    e.nm = nm;
    e.c0 = e0;
    e.c1 = e1;
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge sys_clk);
    #1;
  endtask

  // Combinational controls are sampled mid-cycle, away from the active edge.
  always @(negedge sys_clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      total += 2;
      if ({if0.pc_hold, if0.ifid_hold, if0.ifid_flush, if0.idex_hold, if0.idex_bubble} === mon_e.c0)
        passed++;
      else
        $display("FAIL %s dut0 ctrl got %b want %b", mon_e.nm,
                 {if0.pc_hold, if0.ifid_hold, if0.ifid_flush, if0.idex_hold, if0.idex_bubble}, mon_e.c0);
      if ({if1.pc_hold, if1.ifid_hold, if1.ifid_flush, if1.idex_hold, if1.idex_bubble} === mon_e.c1)
        passed++;
      else
        $display("FAIL %s dut1 ctrl got %b want %b", mon_e.nm,
                 {if1.pc_hold, if1.ifid_hold, if1.ifid_flush, if1.idex_hold, if1.idex_bubble}, mon_e.c1);
    end
  end

  task automatic test_reset();
    in_t s;
    s      = hit_in(5'd5);
    s.pc_sel = 1'b1;
    s.busy = 1'b1;
    s.rst  = 1'b0;
    for (int i = 0; i < 3; i++) drive(s, Z, Z, "rst_hold");
    drive(idle_in(), Z, Z, "rst_release");
    drive(idle_in(), Z, Z, "rst_idle");
    settle();
    total += 4;
    if (if0.stall_cnt === 4'd0) passed++; else $display("FAIL rst_stall0 got %0d want 0", if0.stall_cnt);
    if (if0.flush_cnt === 4'd0) passed++; else $display("FAIL rst_flush0 got %0d want 0", if0.flush_cnt);
    if (if1.stall_cnt === 8'd0) passed++; else $display("FAIL rst_stall1 got %0d want 0", if1.stall_cnt);
    if (if1.flush_cnt === 8'd0) passed++; else $display("FAIL rst_flush1 got %0d want 0", if1.flush_cnt);
  endtask

  task automatic test_load_use();
    in_t s;
    drive(hit_in(5'd5), LU, LU, "lu_rs1");
    drive(idle_in(), Z, LU, "lu_rs1_s1");
    drive(idle_in(), Z, LU, "lu_rs1_s2");
    drive(idle_in(), Z, Z, "lu_rs1_done");
    settle();
    total += 2;
    if (if0.stall_cnt === 4'd1) passed++; else $display("FAIL lu_stall0 got %0d want 1", if0.stall_cnt);
    if (if1.stall_cnt === 8'd3) passed++; else $display("FAIL lu_stall1 got %0d want 3", if1.stall_cnt);
    s     = hit_in(5'd7);
    s.rs1 = 5'd3;
    s.rs2 = 5'd7;
    s.u2  = 1'b1;
    drive(s, LU, LU, "lu_rs2");
    drive(idle_in(), Z, LU, "lu_rs2_s1");
    drive(idle_in(), Z, LU, "lu_rs2_s2");
    drive(idle_in(), Z, Z, "lu_rs2_done");
    settle();
    total += 2;
    if (if0.stall_cnt === 4'd2) passed++; else $display("FAIL lu2_stall0 got %0d want 2", if0.stall_cnt);
    if (if1.stall_cnt === 8'd6) passed++; else $display("FAIL lu2_stall1 got %0d want 6", if1.stall_cnt);
  endtask

  task automatic test_no_hazard();
    in_t s;
    s = hit_in(5'd0);
    drive(s, Z, Z, "nh_rd0");
    s = hit_in(5'd5);
    s.u1 = 1'b0;
    s.rs2 = 5'd5;
    drive(s, Z, Z, "nh_unused");
    s = hit_in(5'd5);
    s.wb = 2'b01;
    drive(s, Z, Z, "nh_alu");
    s = hit_in(5'd5);
    s.rs1 = 5'd4;
    drive(s, Z, Z, "nh_other_reg");
    settle();
    total += 2;
    if (if0.stall_cnt === 4'd2) passed++; else $display("FAIL nh_stall0 got %0d want 2", if0.stall_cnt);
    if (if1.stall_cnt === 8'd6) passed++; else $display("FAIL nh_stall1 got %0d want 6", if1.stall_cnt);
  endtask

  task automatic test_flush();
    drive(pcsel_in(), FL, FL, "fl_redirect");
    drive(idle_in(), FL, FL, "fl_c1");
    drive(idle_in(), Z, FL, "fl_c2");
    drive(idle_in(), Z, Z, "fl_done");
    settle();
    total += 3;
    if (if0.flush_cnt === 4'd1) passed++; else $display("FAIL fl_flush0 got %0d want 1", if0.flush_cnt);
    if (if1.flush_cnt === 8'd1) passed++; else $display("FAIL fl_flush1 got %0d want 1", if1.flush_cnt);
    if (if0.stall_cnt === 4'd2) passed++; else $display("FAIL fl_stall0 got %0d want 2", if0.stall_cnt);
  endtask

  task automatic test_freeze();
    in_t s;
    drive(pcsel_in(), FL, FL, "fz_redirect");
    for (int i = 0; i < 4; i++) drive(busy_in(), FZ, FZ, "fz_in_flush");
    drive(idle_in(), FL, FL, "fz_resume_flush");
    drive(idle_in(), Z, FL, "fz_flush_tail");
    drive(idle_in(), Z, Z, "fz_flush_done");
    settle();
    total += 4;
    if (if0.stall_cnt === 4'd6)  passed++; else $display("FAIL fz_stall0 got %0d want 6", if0.stall_cnt);
    if (if1.stall_cnt === 8'd10) passed++; else $display("FAIL fz_stall1 got %0d want 10", if1.stall_cnt);
    if (if0.flush_cnt === 4'd2)  passed++; else $display("FAIL fz_flush0 got %0d want 2", if0.flush_cnt);
    if (if1.flush_cnt === 8'd2)  passed++; else $display("FAIL fz_flush1 got %0d want 2", if1.flush_cnt);
    drive(hit_in(5'd9), LU, LU, "fz_lu");
    for (int i = 0; i < 2; i++) drive(busy_in(), FZ, FZ, "fz_in_stall");
    drive(idle_in(), Z, LU, "fz_resume_stall");
    drive(idle_in(), Z, LU, "fz_stall_tail");
    drive(idle_in(), Z, Z, "fz_stall_done");
    s = hit_in(5'd9);
    s.pc_sel = 1'b1;
    s.busy = 1'b1;
    drive(s, FZ, FZ, "fz_busy_wins");
    drive(idle_in(), Z, Z, "fz_busy_drop");
    settle();
    total += 4;
    if (if0.stall_cnt === 4'd10) passed++; else $display("FAIL fz2_stall0 got %0d want 10", if0.stall_cnt);
    if (if1.stall_cnt === 8'd16) passed++; else $display("FAIL fz2_stall1 got %0d want 16", if1.stall_cnt);
    if (if0.flush_cnt === 4'd2)  passed++; else $display("FAIL fz2_flush0 got %0d want 2", if0.flush_cnt);
    if (if1.flush_cnt === 8'd2)  passed++; else $display("FAIL fz2_flush1 got %0d want 2", if1.flush_cnt);
  endtask

  task automatic test_priority();
    in_t s;
    s = hit_in(5'd12);
    s.pc_sel = 1'b1;
    drive(s, FL, FL, "pri_redirect_over_lu");
    drive(idle_in(), FL, FL, "pri_c1");
    drive(idle_in(), Z, FL, "pri_c2");
    drive(idle_in(), Z, Z, "pri_done");
    settle();
    total += 3;
    if (if0.stall_cnt === 4'd10) passed++; else $display("FAIL pri_stall0 got %0d want 10", if0.stall_cnt);
    if (if0.flush_cnt === 4'd3)  passed++; else $display("FAIL pri_flush0 got %0d want 3", if0.flush_cnt);
    if (if1.flush_cnt === 8'd3)  passed++; else $display("FAIL pri_flush1 got %0d want 3", if1.flush_cnt);
  endtask

  task automatic test_saturate();
    in_t s;
    for (int i = 0; i < 8; i++) drive(busy_in(), FZ, FZ, "sat_busy");
    drive(idle_in(), Z, Z, "sat_busy_drop");
    settle();
    total += 2;
    if (if0.stall_cnt === 4'hF)  passed++; else $display("FAIL sat_stall0 got %0d want 15", if0.stall_cnt);
    if (if1.stall_cnt === 8'd24) passed++; else $display("FAIL sat_stall1 got %0d want 24", if1.stall_cnt);
    for (int i = 0; i < 14; i++) begin
      drive(pcsel_in(), FL, FL, "sat_redirect");
      drive(idle_in(), FL, FL, "sat_fl1");
      drive(idle_in(), Z, FL, "sat_fl2");
    end
    drive(hit_in(5'd3), LU, LU, "sat_lu");
    drive(idle_in(), Z, LU, "sat_lu_s1");
    drive(idle_in(), Z, LU, "sat_lu_s2");
    drive(idle_in(), Z, Z, "sat_lu_done");
    settle();
    total += 4;
    if (if0.flush_cnt === 4'hF)  passed++; else $display("FAIL sat_flush0 got %0d want 15", if0.flush_cnt);
    if (if1.flush_cnt === 8'd17) passed++; else $display("FAIL sat_flush1 got %0d want 17", if1.flush_cnt);
    if (if0.stall_cnt === 4'hF)  passed++; else $display("FAIL sat_hold0 got %0d want 15", if0.stall_cnt);
    if (if1.stall_cnt === 8'd27) passed++; else $display("FAIL sat_hold1 got %0d want 27", if1.stall_cnt);
    s = busy_in();
    s.clr = 1'b1;
    drive(s, FZ, FZ, "clr_busy");
    s = pcsel_in();
    s.clr = 1'b1;
    drive(s, FL, FL, "clr_redirect");
    drive(idle_in(), FL, FL, "clr_fl1");
    drive(idle_in(), Z, FL, "clr_fl2");
    drive(idle_in(), Z, Z, "clr_done");
    settle();
    total += 4;
    if (if0.stall_cnt === 4'd0) passed++; else $display("FAIL clr_stall0 got %0d want 0", if0.stall_cnt);
    if (if1.stall_cnt === 8'd0) passed++; else $display("FAIL clr_stall1 got %0d want 0", if1.stall_cnt);
    if (if0.flush_cnt === 4'd0) passed++; else $display("FAIL clr_flush0 got %0d want 0", if0.flush_cnt);
    if (if1.flush_cnt === 8'd0) passed++; else $display("FAIL clr_flush1 got %0d want 0", if1.flush_cnt);
  endtask

  task automatic test_back_to_back();
    drive(hit_in(5'd5), LU, LU, "b2b_lu1");
    drive(hit_in(5'd6), LU, LU, "b2b_lu2");
    drive(hit_in(5'd7), LU, LU, "b2b_lu3");
    drive(hit_in(5'd8), LU, LU, "b2b_lu4");
    drive(idle_in(), Z, LU, "b2b_s1");
    drive(idle_in(), Z, LU, "b2b_s2");
    drive(idle_in(), Z, Z, "b2b_lu_done");
    drive(pcsel_in(), FL, FL, "b2b_redirect1");
    drive(idle_in(), FL, FL, "b2b_fl1");
    drive(idle_in(), Z, FL, "b2b_fl2");
    drive(pcsel_in(), FL, FL, "b2b_redirect2");
    drive(idle_in(), FL, FL, "b2b_fl3");
    drive(idle_in(), Z, FL, "b2b_fl4");
    drive(idle_in(), Z, Z, "b2b_done");
    settle();
    total += 4;
    if (if0.stall_cnt === 4'd4) passed++; else $display("FAIL b2b_stall0 got %0d want 4", if0.stall_cnt);
    if (if1.stall_cnt === 8'd6) passed++; else $display("FAIL b2b_stall1 got %0d want 6", if1.stall_cnt);
    if (if0.flush_cnt === 4'd2) passed++; else $display("FAIL b2b_flush0 got %0d want 2", if0.flush_cnt);
    if (if1.flush_cnt === 8'd2) passed++; else $display("FAIL b2b_flush1 got %0d want 2", if1.flush_cnt);
  endtask

  task automatic test_reset_mid();
    in_t s;
    drive(pcsel_in(), FL, FL, "mid_redirect");
    s = idle_in();
    s.rst = 1'b0;
    drive(s, Z, Z, "mid_rst_async");
    drive(idle_in(), Z, Z, "mid_after_rst");
    drive(idle_in(), Z, Z, "mid_idle");
    settle();
    total += 4;
    if (if0.stall_cnt === 4'd0) passed++; else $display("FAIL mid_stall0 got %0d want 0", if0.stall_cnt);
    if (if1.stall_cnt === 8'd0) passed++; else $display("FAIL mid_stall1 got %0d want 0", if1.stall_cnt);
    if (if0.flush_cnt === 4'd0) passed++; else $display("FAIL mid_flush0 got %0d want 0", if0.flush_cnt);
    if (if1.flush_cnt === 8'd0) passed++; else $display("FAIL mid_flush1 got %0d want 0", if1.flush_cnt);
  endtask

  initial begin
    in_t s;
    s = idle_in();
    s.rst = 1'b0;
    apply(s);
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_freeze();
    test_priority();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    settle();
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
